mutex_arbiter2: RTL
===================

MUTEX_ARBITER2 -- requirements
Module: mutex_arbiter2

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 8, maximum consecutive grant cycles per owner (legal range 2..255).
REQ-002 SHALL have parameter: CNT_W, $clog2(MAX_HOLD+1), width of hold counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: clock  input  1  rising-edge clock.
REQ-005 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port: req_a  input  1  requester A wants the shared resource.
REQ-007 SHALL have port: req_b  input  1  requester B wants the shared resource.
REQ-008 SHALL have port: done_a  input  1  A releases; ignored unless gnt_a=1.
REQ-009 SHALL have port: done_b  input  1  B releases; ignored unless gnt_b=1.
REQ-010 SHALL have port: gnt_a  output  1  A owns resource (registered).
REQ-011 SHALL have port: gnt_b  output  1  B owns resource (registered).
REQ-012 SHALL have port: timeout  output  1  one-cycle pulse: grant revoked by MAX_HOLD expiry.
REQ-013 SHALL have port: hold_cnt  output  CNT_W  cycles current owner has held the grant.

Function
REQ-014 SHALL implement FSM with states IDLE, GNT_A, GNT_B, GAP; all outputs registered.
REQ-015 SHALL guarantee gnt_a && gnt_b is never 1 on any cycle.
REQ-016 IDLE: req_a only -> GNT_A; req_b only -> GNT_B; neither -> stay IDLE.
REQ-017 IDLE with req_a=req_b=1: grant requester not served last (last pointer), round-robin.
REQ-018 Grant latency SHALL be 1 cycle: request sampled in IDLE at edge N, gnt visible after edge N+1... i.e. gnt high in cycle following the sampling edge.
REQ-019 Entering GNT_x SHALL set hold_cnt=0 and update last pointer to x.
REQ-020 In GNT_x hold_cnt SHALL increment by 1 each cycle, never wrapping.
REQ-021 GNT_x -> GAP when done_x=1, or req_x=0, or hold_cnt=MAX_HOLD-1; gnt_x deasserts in GAP.
REQ-022 timeout SHALL pulse 1 for the single GAP cycle only if exit was due to hold_cnt expiry with done_x=0 and req_x=1; done_x on the expiry cycle takes priority (no timeout).
REQ-023 GAP SHALL last exactly one cycle (both grants 0, break-before-make) then go to IDLE; hold_cnt reads 0 in GAP and IDLE.
REQ-024 Minimum spacing between any two grants SHALL be 2 idle cycles (GAP + IDLE arbitration).
REQ-025 done_x asserted while not granted, and done_x with req_x=0 in IDLE, SHALL have no effect.

Reset
REQ-026 On reset: state=IDLE, gnt_a=0, gnt_b=0, timeout=0, hold_cnt=0, last pointer=B (A wins first tie).
REQ-027 Reset asserted mid-grant SHALL drop the grant on the next edge with no GAP and no timeout pulse.

Configuration
REQ-028 Macro MUTEX_ARB_ASSERT_EN defined: SHALL compile concurrent assertions clocked on posedge clock, disabled during reset: !(gnt_a && gnt_b); $rose(gnt_x) implies $past(req_x); hold_cnt < MAX_HOLD.
REQ-029 Macro undefined: no assertion code compiled; RTL behaviour identical.

Structure
REQ-030 Package mutex_arb_pkg SHALL hold the state enum typedef (IDLE, GNT_A, GNT_B, GAP) and default MAX_HOLD constant.
REQ-031 Sub-module hold_timer (clear, enable, count, expired) SHALL implement the hold counter.

Verification
REQ-032 After reset, req_a=1 only, held, done_a pulsed at hold_cnt=3 -> gnt_a high 4 cycles, GAP, IDLE; timeout=0.
REQ-033 req_a=req_b=1 continuously, done never -> grants alternate A,B,A with 8 cycles each, timeout pulse in every GAP, 2 idle cycles between grants.
REQ-034 gnt_b active, req_a toggling, done_a pulsed -> gnt_a stays 0, no state change.
REQ-035 reset asserted at hold_cnt=5 of GNT_A -> next cycle gnt_a=0, hold_cnt=0, timeout=0; next tie grants A.
REQ-036 32-cycle random req/done stimulus with MUTEX_ARB_ASSERT_EN defined -> zero assertion failures, gnt_a && gnt_b never 1.

Source files
------------

// File: rtl/mutex_arb_pkg.sv
// Shared types and defaults for the two-requester mutex arbiter.
//   state_t          : arbiter FSM encoding (IDLE, GNT_A, GNT_B, GAP)
//   owner_t          : round-robin "last served" pointer
//   DEFAULT_MAX_HOLD : default maximum consecutive grant cycles per owner
package mutex_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2,
    GAP   = 2'd3
  } state_t;

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } owner_t;

  localparam int unsigned DEFAULT_MAX_HOLD = 8;

endpackage

// File: rtl/hold_timer.sv
// Hold-time counter for the current grant owner.
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset
//   clear   : force count to 0 on the next edge (wins over enable)
//   enable  : advance count by one; saturates at MAX_HOLD-1, never wraps
//   count   : registered cycles-held value
//   expired : count has reached MAX_HOLD-1 (last permitted grant cycle)
module hold_timer
  import mutex_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_HOLD - 1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST_CNT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST_CNT);

endmodule

// File: rtl/mutex_arbiter2.sv
// Two-requester mutual-exclusion arbiter with bounded hold time.
// A grant lasts until the owner signals done, drops its request, or holds
// for MAX_HOLD cycles; every grant is followed by a one-cycle GAP and an
// IDLE arbitration cycle. Ties in IDLE go to the requester not served last.
//   clock    : rising-edge clock
//   reset    : synchronous active-high reset
//   req_a/b  : requests for the shared resource
//   done_a/b : release by the current owner (ignored otherwise)
//   gnt_a/b  : registered grants, never both high
//   timeout  : one-cycle pulse in GAP when the grant was revoked by expiry
//   hold_cnt : cycles the current owner has held the grant (0 outside grants)
// Optional: define MUTEX_ARB_ASSERT_EN to compile protocol assertions.
module mutex_arbiter2
  import mutex_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             done_a,
  input  logic             done_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             timeout,
  output logic [CNT_W-1:0] hold_cnt
);

  state_t state, next_state;
  owner_t last, next_last;
  logic   stay_gnt;
  logic   expired;
  logic   timeout_next;

  always_comb begin
    next_state   = state;
    next_last    = last;
    stay_gnt     = 1'b0;
    timeout_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_a && req_b) next_state = (last == LAST_B) ? GNT_A : GNT_B;
        else if (req_a)     next_state = GNT_A;
        else if (req_b)     next_state = GNT_B;
      end
      GNT_A: begin
        if (done_a || !req_a || expired) begin
          next_state   = GAP;
          timeout_next = expired && !done_a && req_a;
        end else begin
          stay_gnt = 1'b1;
        end
      end
      GNT_B: begin
        if (done_b || !req_b || expired) begin
          next_state   = GAP;
          timeout_next = expired && !done_b && req_b;
        end else begin
          stay_gnt = 1'b1;
        end
      end
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (state == IDLE && next_state == GNT_A) next_last = LAST_A;
    if (state == IDLE && next_state == GNT_B) next_last = LAST_B;
  end

  // Counter runs only while a grant continues; entering a grant, GAP and
  // IDLE all clear it so hold_cnt reads 0 there.
  hold_timer #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!stay_gnt),
    .enable  (stay_gnt),
    .count   (hold_cnt),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      last    <= LAST_B;
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= next_state;
      last    <= next_last;
      gnt_a   <= (next_state == GNT_A);
      gnt_b   <= (next_state == GNT_B);
      timeout <= timeout_next;
    end
  end

`ifdef MUTEX_ARB_ASSERT_EN
  a_mutex: assert property (@(posedge clock) disable iff (reset)
    !(gnt_a && gnt_b));
  a_rose_a: assert property (@(posedge clock) disable iff (reset)
    $rose(gnt_a) |-> $past(req_a));
  a_rose_b: assert property (@(posedge clock) disable iff (reset)
    $rose(gnt_b) |-> $past(req_b));
  a_hold: assert property (@(posedge clock) disable iff (reset)
    hold_cnt < CNT_W'(MAX_HOLD));
`else
  // Assertions not compiled in this build.
`endif

endmodule
